// File: rtl/clock_counter.sv
// rtl/clock_counter.sv - free-running modulo-MAX_COUNT cycle counter
`timescale 1ns/1ps
module clock_counter #(
    parameter int MAX_COUNT = 100
) (
    input  logic               clock,
    input  logic               reset,
    output logic signed [31:0] amount
);

    if (MAX_COUNT < 1) begin : g_bad_max_count
        $fatal(1, "clock_counter: MAX_COUNT must be at least 1");
    end

    localparam logic signed [31:0] LAST = 32'(MAX_COUNT - 1);

    logic signed [31:0] amount_q;
    logic signed [31:0] amount_d;

    // Wrapping at >= LAST keeps amount+1 <= MAX_COUNT-1, so the sign bit is never reached.
    always_comb begin
        amount_d = amount_q + 32'sd1;
        if (amount_q >= LAST) begin
            amount_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            amount_q <= '0;
        end else begin
            amount_q <= amount_d;
        end
    end

    assign amount = amount_q;

endmodule

// File: tb/tb_clock_counter.sv
// tb/tb_clock_counter.sv - scoreboard bench for clock_counter at MAX_COUNT 100, 1 and 2
`timescale 1ns/1ps
module tb_clock_counter;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic signed [31:0] amount_100;
    logic signed [31:0] amount_1;
    logic signed [31:0] amount_2;

    always #5 clock = ~clock;

    clock_counter #(.MAX_COUNT(100)) u_dut_100 (.clock(clock), .reset(reset), .amount(amount_100));
    clock_counter #(.MAX_COUNT(1))   u_dut_1   (.clock(clock), .reset(reset), .amount(amount_1));
    clock_counter #(.MAX_COUNT(2))   u_dut_2   (.clock(clock), .reset(reset), .amount(amount_2));

    typedef struct {
        int edge_n;
        bit rst;
        int exp100;
        int exp1;
        int exp2;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   checks      = 0;
    int   failures    = 0;
    int   edge_cnt    = 0;
    int   since       = -1;
    int   model_wraps = 0;
    int   seen_wraps  = 0;
    logic signed [31:0] prev100 = 32'sd0;

    always @(posedge clock) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input int edge_n,
                         input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_n, act, exp);
        end
    endtask

    // Reference: the counter value is simply the number of edges since the last
    // reset edge, taken modulo MAX_COUNT.
    task automatic step(input bit r);
        @(posedge clock);
        #1;
        reset = r;
        if (r) since = 0;
        else if (since >= 0) since++;
        if (since >= 0) begin
            if (!r && since > 0 && since % 100 == 0) model_wraps++;
            sb_q.push_back('{edge_n: edge_cnt + 1, rst: r,
                             exp100: since % 100, exp1: since % 1, exp2: since % 2});
        end
    endtask

    always @(negedge clock) begin
        if (sb_q.size() > 0 && sb_q[0].edge_n == edge_cnt) begin
            cur = sb_q.pop_front();
            check("amount_max100", cur.edge_n, amount_100, cur.exp100);
            check("amount_max1",   cur.edge_n, amount_1,   cur.exp1);
            check("amount_max2",   cur.edge_n, amount_2,   cur.exp2);
            if (!cur.rst && prev100 == 32'sd99 && amount_100 == 32'sd0) seen_wraps++;
            prev100 = amount_100;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d actual=running required=finished", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        step(1'b1); step(1'b0); step(1'b0); step(1'b0);

        step(1'b1);
        repeat (400) step(1'b0);

        step(1'b1);
        repeat (57) step(1'b0);
        step(1'b1);
        repeat (5) step(1'b0);

        repeat (10) step(1'b1);
        repeat (3) step(1'b0);

        repeat (3000) step($urandom_range(0, 31) == 0);
        step(1'b0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        checks++;
        if (seen_wraps != model_wraps) begin
            failures++;
            $display("FAIL wrap_count actual=%0d required=%0d", seen_wraps, model_wraps);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_counter.md
CLOCK_COUNTER -- requirements
Module: clock_counter

Interface
REQ-001 Parameter: MAX_COUNT, default 100, number of distinct count values; counter spans 0..MAX_COUNT-1, legal range 1..2147483647.
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 Port: amount  output  32 (signed integer type)  current cycle count since last reset or wrap.
REQ-005 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high, with ports named clock and reset.

Function
REQ-006 amount SHALL be driven directly from a register; no combinational path from any input to amount.
REQ-007 On each rising edge with reset=0 and amount < MAX_COUNT-1, amount SHALL become amount+1.
REQ-008 On a rising edge with reset=0 and amount = MAX_COUNT-1, amount SHALL wrap to 0 on that edge.
REQ-009 Increment-to-visible latency SHALL be one clock edge: the value after edge N is visible on amount until edge N+1.
REQ-010 amount SHALL never take a negative value or a value >= MAX_COUNT after the first reset.
REQ-011 With MAX_COUNT=1, amount SHALL remain 0 on every edge.
REQ-012 Arithmetic SHALL be performed at 32 bits; the wrap compare SHALL prevent any overflow into the sign bit for every legal MAX_COUNT, including 2147483647.
REQ-013 If reset and wrap condition coincide on the same edge, reset SHALL take priority; the result is 0 either way.
REQ-014 Counting SHALL be unconditional when reset=0; there is no enable, load or stall input.
REQ-015 An out-of-range MAX_COUNT (< 1) SHALL be rejected at elaboration with a fatal error or an assertion.

Reset
REQ-016 On any rising edge with reset=1, amount SHALL become 0 regardless of its current value.
REQ-017 While reset is held high for multiple cycles, amount SHALL stay 0.
REQ-018 After reset is deasserted, the first rising edge with reset=0 SHALL produce amount=1.
REQ-019 Assertion of reset mid-count, such as amount=57, SHALL clear amount to 0 on the next rising edge with no intermediate values.
REQ-020 Before the first reset edge, amount is unspecified; the bench SHALL NOT check it.

Verification
REQ-021 Scenario 1: reset=1 for one edge, then reset=0 -> amount=0 after the reset edge, then 1, 2, 3 on successive edges.
REQ-022 Scenario 2: default MAX_COUNT=100, free-run from reset -> amount reaches 99 on the 99th edge after reset release and reads 0 on the 100th.
REQ-023 Scenario 3: run 400 edges after reset -> exactly 4 wraps; amount = 0 after edges 100, 200, 300, 400; the sequence is strictly +1 otherwise.
REQ-024 Scenario 4: assert reset when amount=57 -> amount=0 on the next edge; after release it counts 1, 2, ...
REQ-025 Scenario 5: hold reset high for 10 edges -> amount=0 throughout; the first edge after release gives 1.
REQ-026 Scenario 6: MAX_COUNT=1 instance -> amount=0 for 20 consecutive edges; MAX_COUNT=2 instance -> amount alternates 1, 0, 1, 0.
